// File: rtl/logicbox_deser_pkg.sv
// logicbox_pkg: shared definitions for the LOGICBOX serial receiver.
// Contents: FSM state encoding, line level constants and the parity-enable
// flag. Optional feature macro: LOGICBOX_DESER_PARITY_EN. When it is defined,
// an even-parity bit sits between the last data bit and the stop bit.
package logicbox_pkg;

   // Line levels of the single-wire frame.
   localparam logic LB_IDLE_LEVEL  = 1'b1;
   localparam logic LB_START_LEVEL = 1'b0;

`ifdef LOGICBOX_DESER_PARITY_EN
   localparam bit LB_PARITY_EN = 1'b1;
`else
   localparam bit LB_PARITY_EN = 1'b0;
`endif

   // Receiver FSM states. The PARITY state exists only in the parity build.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
`ifdef LOGICBOX_DESER_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_STOP   = 2'd3
   } lb_state_t;

endpackage

// File: rtl/logicbox_deser_if.sv
// logicbox_deser_if: received-word output port of logicbox_deser.
// Signals: O_DATA (word, bit 0 first on the wire), O_VALID (unconsumed word),
// O_READY (consumer accept), O_ERR (framing/parity error pulse),
// O_OVF (good frame dropped pulse).
// master: the receiver side. slave: the consumer side.
interface logicbox_deser_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] O_DATA;
   logic             O_VALID;
   logic             O_READY;
   logic             O_ERR;
   logic             O_OVF;

   modport master (
      output O_DATA,
      output O_VALID,
      output O_ERR,
      output O_OVF,
      input  O_READY
   );

   modport slave (
      input  O_DATA,
      input  O_VALID,
      input  O_ERR,
      input  O_OVF,
      output O_READY
   );
endinterface

// File: rtl/logicbox_deser_buf.sv
// logicbox_deser_buf: one-entry holding register with valid/ready handshake.
// Ports: CLK, RST (sync, active high); load/load_data: a good frame has just
// completed; ready: consumer accept; data/valid: held word; ovf: one-cycle
// pulse when a good frame is dropped because the entry is full and not
// being consumed in the same cycle. All outputs are registered.
module logicbox_deser_buf
   import logicbox_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             ovf
);

   // Holding register update: load, consume, or drop with overflow.
   always_ff @(posedge CLK) begin
      if (RST) begin
         data  <= '0;
         valid <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         ovf <= 1'b0;
         if (load) begin
            // An entry consumed in this same cycle frees room for the new word.
            if (!valid || ready) begin
               data  <= load_data;
               valid <= 1'b1;
            end else begin
               ovf <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end else begin
            valid <= valid;
         end
      end
   end

endmodule

// File: rtl/logicbox_deser.sv
// logicbox_deser: serial-to-parallel receiver for the LOGICBOX data path.
// Ports: CLK (rising edge), RST (sync, active high), I (serial in, idle 1),
// o_port (logicbox_deser_if.master: O_DATA, O_VALID, O_READY, O_ERR, O_OVF).
// Frame: start 0, WIDTH data bits LSB first, [even parity], stop 1.
// Optional feature macro: LOGICBOX_DESER_PARITY_EN enables the parity bit.
module logicbox_deser
   import logicbox_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I,
   logicbox_deser_if.master  o_port
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   lb_state_t        state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] shift_r;
   logic             par_err_r;
   logic             err_r;
   logic [WIDTH:0]   shift_wide_s;
   logic             load_s;

   // Even parity over the received data bits.
   function automatic logic even_par(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   // Right shift with the new bit entering at the MSB; works for WIDTH=1 too.
   assign shift_wide_s = {I, shift_r};

   // The frame is good when the stop bit is at idle level and parity matched.
   assign load_s = (state_r == ST_STOP) && (I == LB_IDLE_LEVEL) && !par_err_r;

   // Frame FSM, bit counter, shift register and error pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         shift_r   <= '0;
         par_err_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (I == LB_START_LEVEL) begin
                  state_r   <= ST_DATA;
                  cnt_r     <= '0;
                  par_err_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_DATA: begin
               shift_r <= shift_wide_s[WIDTH:1];
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= '0;
`ifdef LOGICBOX_DESER_PARITY_EN
                  state_r <= ST_PARITY;
`else
                  state_r <= ST_STOP;
`endif
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
`ifdef LOGICBOX_DESER_PARITY_EN
            ST_PARITY: begin
               par_err_r <= I ^ even_par(shift_r);
               state_r   <= ST_STOP;
            end
`endif
            ST_STOP: begin
               // A bad stop bit is consumed here; it never restarts a frame.
               err_r   <= (I != LB_IDLE_LEVEL) || par_err_r;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   logicbox_deser_buf #(.WIDTH(WIDTH)) u_buf (
      .CLK       (CLK),
      .RST       (RST),
      .load      (load_s),
      .load_data (shift_r),
      .ready     (o_port.O_READY),
      .data      (o_port.O_DATA),
      .valid     (o_port.O_VALID),
      .ovf       (o_port.O_OVF)
   );

   assign o_port.O_ERR = err_r;

endmodule

// File: tb/tb_logicbox_deser.sv
// tb_logicbox_deser: directed scoreboard bench for logicbox_deser (WIDTH=8).
// Stimulus pushes expected words and error/overflow events into queues; a
// monitor on the falling edge pops and compares whenever the DUT presents them.
module tb_logicbox_deser;
   import logicbox_pkg::*;

   localparam int W = 8;
   localparam int EV_ERR = 1;
   localparam int EV_OVF = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic I   = 1'b1;

   logicbox_deser_if #(.WIDTH(W)) bus ();

   logicbox_deser #(.WIDTH(W)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .I      (I),
      .o_port (bus.master)
   );

   always #5 CLK = ~CLK;

   logic [W-1:0] exp_q[$];
   int           evt_q[$];
   int           checks = 0;
   int           errors = 0;

   // Scoreboard monitor: accepted words and error/overflow pulses.
   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.O_VALID && bus.O_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL word_unexpected: got %h, required none", bus.O_DATA);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (bus.O_DATA !== e) begin
                  errors++;
                  $display("FAIL word: got %h, required %h", bus.O_DATA, e);
               end
            end
         end
         if (bus.O_ERR === 1'b1 || bus.O_OVF === 1'b1) begin
            int code;
            code = (bus.O_ERR === 1'b1 ? EV_ERR : 0) + (bus.O_OVF === 1'b1 ? EV_OVF : 0);
            checks++;
            if (evt_q.size() == 0) begin
               errors++;
               $display("FAIL event_unexpected: got %0d, required none", code);
            end else begin
               int e;
               e = evt_q.pop_front();
               if (code != e) begin
                  errors++;
                  $display("FAIL event: got %0d, required %0d", code, e);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic send_bit(input logic b);
      I = b;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) send_bit(1'b1);
   endtask

   // One frame; rdy_stop raises O_READY together with the stop bit.
   task automatic send_frame(input logic [W-1:0] d, input logic stop_b,
                             input logic par_flip, input logic rdy_stop);
      send_bit(1'b0);
      for (int k = 0; k < W; k++) send_bit(d[k]);
`ifdef LOGICBOX_DESER_PARITY_EN
      send_bit((^d) ^ par_flip);
`endif
      if (rdy_stop) bus.O_READY = 1'b1;
      send_bit(stop_b);
   endtask

   initial begin
      bus.O_READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      check("rst_valid", {31'd0, bus.O_VALID}, 32'd0);
      check("rst_data",  {24'd0, bus.O_DATA}, 32'd0);
      check("rst_err",   {31'd0, bus.O_ERR}, 32'd0);
      check("rst_ovf",   {31'd0, bus.O_OVF}, 32'd0);
      idle(2);

      // Basic frame 0xA5, visible the cycle after stop, for one cycle only.
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check("a5_valid", {31'd0, bus.O_VALID}, 32'd1);
      check("a5_data",  {24'd0, bus.O_DATA}, 32'h0000_00A5);
      send_bit(1'b1);
      check("a5_one_cycle", {31'd0, bus.O_VALID}, 32'd0);

      // Bad stop bit, then a correct frame.
      evt_q.push_back(EV_ERR);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check("stop_err_pulse", {31'd0, bus.O_ERR}, 32'd1);
      check("stop_err_novalid", {31'd0, bus.O_VALID}, 32'd0);
      send_bit(1'b1);
      check("stop_err_one_cycle", {31'd0, bus.O_ERR}, 32'd0);
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Overflow: 0x11 held, 0x22 dropped back-to-back.
      bus.O_READY = 1'b0;
      exp_q.push_back(8'h11);
      evt_q.push_back(EV_OVF);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      check("ovf_pulse", {31'd0, bus.O_OVF}, 32'd1);
      check("ovf_hold_data", {24'd0, bus.O_DATA}, 32'h0000_0011);
      idle(3);
      check("ovf_stable_data", {24'd0, bus.O_DATA}, 32'h0000_0011);
      check("ovf_stable_valid", {31'd0, bus.O_VALID}, 32'd1);
      bus.O_READY = 1'b1;
      idle(2);
      check("ovf_drained", {31'd0, bus.O_VALID}, 32'd0);

      // Accept at the same edge a new frame completes: no overflow.
      bus.O_READY = 1'b0;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1);
      check("swap_valid", {31'd0, bus.O_VALID}, 32'd1);
      check("swap_data", {24'd0, bus.O_DATA}, 32'h0000_0022);
      check("swap_no_ovf", {31'd0, bus.O_OVF}, 32'd0);
      idle(2);

      // Reset after data bit 4, then a fresh frame.
      send_bit(1'b0);
      for (int k = 0; k < 5; k++) send_bit(k[0]);
      RST = 1'b1;
      I = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check("midrst_valid", {31'd0, bus.O_VALID}, 32'd0);
      check("midrst_data", {24'd0, bus.O_DATA}, 32'd0);
      check("midrst_err", {31'd0, bus.O_ERR}, 32'd0);
      idle(W + 4);
      check("midrst_no_late_err", {31'd0, bus.O_ERR}, 32'd0);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
      check("7e_data", {24'd0, bus.O_DATA}, 32'h0000_007E);
      idle(2);

`ifdef LOGICBOX_DESER_PARITY_EN
      exp_q.push_back(8'h03);
      send_frame(8'h03, 1'b1, 1'b0, 1'b0);
      check("par_ok_valid", {31'd0, bus.O_VALID}, 32'd1);
      idle(2);
      evt_q.push_back(EV_ERR);
      send_frame(8'h03, 1'b1, 1'b1, 1'b0);
      check("par_bad_err", {31'd0, bus.O_ERR}, 32'd1);
      check("par_bad_novalid", {31'd0, bus.O_VALID}, 32'd0);
      idle(2);
`endif

      // Bounded drain of the scoreboard.
      for (int k = 0; k < 50; k++) begin
         if (exp_q.size() == 0 && evt_q.size() == 0) break;
         send_bit(1'b1);
      end
      check("words_left", exp_q.size(), 32'd0);
      check("events_left", evt_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
